// File: rtl/frame_arb_pkg.sv
// Shared types and helpers for frame-granular round-robin arbiters.
package frame_arb_pkg;

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  localparam int unsigned MaxReq = 16;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit of req searching upward from last+1, wrapping modulo n.
  function automatic logic [3:0] rr_next(input logic [MaxReq-1:0] req,
                                         input logic [3:0]        last,
                                         input int unsigned       n);
    logic [3:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= MaxReq; i++) begin
      if (i <= n) begin
        idx = (32'(last) + i) % n;
        if (!found && req[idx]) begin
          pick  = 4'(idx);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: next requester after last_i, with wrap.
module rr_pick
  import frame_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = id_width(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    last_i,
  output logic [IdW-1:0]    grant_o,
  output logic              any_o
);

  logic [MaxReq-1:0] req_ext;
  logic [3:0]        pick;

  assign req_ext = MaxReq'(req_i);
  assign pick    = rr_next(req_ext, 4'(last_i), NumReq);
  assign grant_o = IdW'(pick);
  assign any_o   = |req_i;

endmodule

// File: rtl/frame_rr_arbiter.sv
// Grants one upstream socket a whole frame at a time into a shared stage,
// round-robin among full sockets, gated on the downstream socket being empty.
module frame_rr_arbiter
  import frame_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FRAME_SIZE = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_REQ-1:0]              i_full,
  input  logic                            i_dst_empty,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_data,
  input  logic [NUM_REQ-1:0]              i_dv,
  output logic [NUM_REQ-1:0]              o_rd_en,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic                            o_dv,
  output logic [id_width(NUM_REQ)-1:0]    o_id,
  output logic                            o_busy,
  output logic                            o_err
);

  localparam int unsigned IdW   = id_width(NUM_REQ);
  localparam int unsigned CntW  = $clog2(FRAME_SIZE + 1);
  localparam int unsigned ToW   = $clog2(FRAME_SIZE + TIMEOUT + 1);
  localparam int unsigned Limit = FRAME_SIZE + TIMEOUT - 1;

  state_e                state_q, state_d;
  logic [IdW-1:0]        grant_q, grant_d, last_q, last_d, id_q, id_d, pick;
  logic                  any_req;
  logic [CntW-1:0]       rd_cnt_q, rd_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [ToW-1:0]        to_cnt_q, to_cnt_d;
  logic [NUM_REQ-1:0]    rd_en_q, rd_en_d, grant_oh;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  dv_q, dv_d, busy_q, busy_d, err_q, err_d;
  logic                  active, dv_own, stray;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_words
    assign words[k] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NumReq (NUM_REQ),
    .IdW    (IdW)
  ) u_rr_pick (
    .req_i   (i_full),
    .last_i  (last_q),
    .grant_o (pick),
    .any_o   (any_req)
  );

  assign grant_oh = NUM_REQ'(1) << grant_q;
  assign active   = (state_q != StIdle);
  assign dv_own   = active && i_dv[grant_q];
  // Any valid not belonging to the current grant is dropped and flagged.
  assign stray    = active ? |(i_dv & ~grant_oh) : |i_dv;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    rd_cnt_d = rd_cnt_q;
    rx_cnt_d = rx_cnt_q;
    to_cnt_d = to_cnt_q;
    rd_en_d  = '0;
    data_d   = data_q;
    dv_d     = 1'b0;
    id_d     = id_q;
    err_d    = err_q | stray;

    if (dv_own) begin
      data_d   = words[grant_q];
      dv_d     = 1'b1;
      id_d     = grant_q;
      rx_cnt_d = rx_cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (i_dst_empty && any_req) begin
          state_d  = StRead;
          grant_d  = pick;
          last_d   = pick;
          rd_en_d  = NUM_REQ'(1) << pick;
          rd_cnt_d = '0;
          rx_cnt_d = '0;
          to_cnt_d = '0;
        end
      end
      StRead: begin
        to_cnt_d = to_cnt_q + ToW'(1);
        if (rd_cnt_q == CntW'(FRAME_SIZE - 1)) begin
          state_d = StDrain;
        end else begin
          rd_en_d  = grant_oh;
          rd_cnt_d = rd_cnt_q + CntW'(1);
        end
      end
      StDrain: begin
        to_cnt_d = to_cnt_q + ToW'(1);
        if (rx_cnt_q >= CntW'(FRAME_SIZE)) begin
          state_d = StIdle;
        end else if (to_cnt_q >= ToW'(Limit)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      last_q   <= IdW'(NUM_REQ - 1);
      rd_cnt_q <= '0;
      rx_cnt_q <= '0;
      to_cnt_q <= '0;
      rd_en_q  <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      id_q     <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      rd_cnt_q <= rd_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      to_cnt_q <= to_cnt_d;
      rd_en_q  <= rd_en_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      id_q     <= id_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign o_rd_en = rd_en_q;
  assign o_data  = data_q;
  assign o_dv    = dv_q;
  assign o_id    = id_q;
  assign o_busy  = busy_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_frame_rr_arbiter.sv
// Directed bench for frame_rr_arbiter: grant-order table plus corner sequences.
module tb_frame_rr_arbiter;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_full;
  logic        i_dst_empty;
  logic [31:0] i_data;
  logic [3:0]  i_dv;
  logic [3:0]  o_rd_en;
  logic [7:0]  o_data;
  logic        o_dv;
  logic [1:0]  o_id;
  logic        o_busy;
  logic        o_err;

  logic [3:0]  sock_dv = '0;
  logic [3:0]  inj_dv;
  logic [7:0]  sock_word [4];
  int          pos [4] = '{default: 0};
  int          short_sock;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  frame_rr_arbiter u_dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_full      (i_full),
    .i_dst_empty (i_dst_empty),
    .i_data      (i_data),
    .i_dv        (i_dv),
    .o_rd_en     (o_rd_en),
    .o_data      (o_data),
    .o_dv        (o_dv),
    .o_id        (o_id),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  // Socket model: word = {socket index, position within the burst}, dv one cycle after rd_en.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (o_rd_en[k]) begin
        sock_dv[k]   <= !(k == short_sock && pos[k] == 3);
        sock_word[k] <= 8'(k * 16 + pos[k]);
        pos[k]       <= pos[k] + 1;
      end else begin
        sock_dv[k] <= 1'b0;
        pos[k]     <= 0;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) i_data[k*8 +: 8] = sock_word[k];
  end
  assign i_dv = sock_dv | inj_dv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (o_rd_en != 4'b0) got = 1'b1;
    end
    check({name, "_grant_wait"}, 32'(got), 32'd1);
  endtask

  // Starts on the first sample showing rd_en; follows the frame until busy drops.
  task automatic watch_frame(input logic [3:0] exp_rd, input logic [1:0] exp_id,
                             input int drop_at, input logic exp_err, input string name);
    int rd_n, dv_n, bad;
    bit done;
    rd_n = 0; dv_n = 0; bad = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (o_rd_en == exp_rd) rd_n++;
      else if (o_rd_en != 4'b0) bad++;
      if (o_dv) begin
        if (o_id != exp_id || o_data != {2'b00, exp_id, 4'(dv_n)}) bad++;
        dv_n++;
      end
      if (drop_at != 0 && rd_n == drop_at) begin
        i_full      = 4'b0;
        i_dst_empty = 1'b0;
      end
      if (!o_busy) done = 1'b1;
      else @(negedge clk);
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_rd_pulses"}, 32'(rd_n), 32'd4);
    check({name, "_words"}, 32'(dv_n), 32'd4);
    check({name, "_bad_samples"}, 32'(bad), 32'd0);
    check({name, "_err"}, 32'(o_err), 32'(exp_err));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] full;
    logic [3:0] exp_rd;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int idle_rd, dvn;
    vecs[0]  = '{4'b1111, 4'b0001, 2'd0};
    vecs[1]  = '{4'b1111, 4'b0010, 2'd1};
    vecs[2]  = '{4'b1111, 4'b0100, 2'd2};
    vecs[3]  = '{4'b1111, 4'b1000, 2'd3};
    vecs[4]  = '{4'b1111, 4'b0001, 2'd0};
    vecs[5]  = '{4'b0100, 4'b0100, 2'd2};
    vecs[6]  = '{4'b1010, 4'b1000, 2'd3};
    vecs[7]  = '{4'b1010, 4'b0010, 2'd1};
    vecs[8]  = '{4'b0001, 4'b0001, 2'd0};
    vecs[9]  = '{4'b0001, 4'b0001, 2'd0};
    vecs[10] = '{4'b0011, 4'b0010, 2'd1};

    i_rst = 1'b1; i_full = '0; i_dst_empty = 1'b1; inj_dv = '0; short_sock = -1;
    #1;
    check("reset_outputs", {o_rd_en, o_data, 3'b0, o_dv, 2'b0, o_id, 3'b0, o_busy, 3'b0, o_err},
          32'd0);
    repeat (2) @(negedge clk);
    i_rst = 1'b0;

    for (int v = 0; v < 11; v++) begin
      i_full = vecs[v].full;
      i_dst_empty = 1'b1;
      wait_grant($sformatf("vec%0d", v));
      check($sformatf("vec%0d_grant", v), 32'(o_rd_en), 32'(vecs[v].exp_rd));
      watch_frame(vecs[v].exp_rd, vecs[v].exp_id, 0, 1'b0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_idle_gap", v), {31'b0, o_busy}, 32'd0);
    end

    // Downstream gate: full held while the destination is occupied.
    i_full = 4'b0001; i_dst_empty = 1'b0; idle_rd = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_rd_en != 4'b0 || o_busy) idle_rd++;
    end
    check("gate_hold", 32'(idle_rd), 32'd0);
    i_dst_empty = 1'b1;
    @(negedge clk);
    check("gate_release", 32'(o_rd_en), 32'b0001);
    watch_frame(4'b0001, 2'd0, 0, 1'b0, "gate");

    // Mid-frame drop of full and dst_empty after the second rd_en.
    i_full = 4'b0010; i_dst_empty = 1'b1;
    wait_grant("drop");
    check("drop_grant", 32'(o_rd_en), 32'b0010);
    watch_frame(4'b0010, 2'd1, 2, 1'b0, "drop");
    i_dst_empty = 1'b1;

    // Timeout: socket 3 withholds its last word.
    short_sock = 3; i_full = 4'b1000;
    wait_grant("tmo");
    dvn = 0;
    for (int i = 1; i <= 13; i++) begin
      if (o_dv) dvn++;
      if (i == 12) begin
        check("tmo_err_before", 32'(o_err), 32'd0);
        check("tmo_busy_before", 32'(o_busy), 32'd1);
      end
      if (i == 13) begin
        check("tmo_err_after", 32'(o_err), 32'd1);
        check("tmo_busy_after", 32'(o_busy), 32'd0);
      end else begin
        @(negedge clk);
      end
    end
    check("tmo_words", 32'(dvn), 32'd3);
    short_sock = -1; i_full = 4'b0100;
    wait_grant("post_tmo");
    check("post_tmo_grant", 32'(o_rd_en), 32'b0100);
    watch_frame(4'b0100, 2'd2, 0, 1'b1, "post_tmo");
    i_full = '0;

    apply_reset();
    check("err_cleared_by_reset", 32'(o_err), 32'd0);

    // Stray valid from socket 0 while socket 2 holds the grant, then reset mid-READ.
    i_full = 4'b0100;
    wait_grant("stray");
    check("stray_grant", 32'(o_rd_en), 32'b0100);
    inj_dv = 4'b0001;
    @(negedge clk);
    inj_dv = 4'b0000;
    check("stray_err", 32'(o_err), 32'd1);
    check("stray_dropped", 32'(o_dv), 32'd0);
    @(negedge clk);
    i_rst = 1'b1; i_full = '0;
    #1;
    check("midreset_outputs", {o_rd_en, o_data, 3'b0, o_dv, 2'b0, o_id, 3'b0, o_busy, 3'b0, o_err},
          32'd0);
    @(negedge clk);
    i_rst = 1'b0;
    dvn = 0;
    repeat (2) begin
      @(negedge clk);
      if (o_dv || o_err) dvn++;
    end
    check("midreset_quiet", 32'(dvn), 32'd0);
    i_full = 4'b1101;
    wait_grant("after_reset");
    check("after_reset_grant", 32'(o_rd_en), 32'b0001);
    watch_frame(4'b0001, 2'd0, 0, 1'b0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
